// File: rtl/inv_sub_bytes_iter_if.sv
// Handshake bundle for the iterative InvSubBytes engine: input block channel
// and output result channel, each with its own valid/ready pair.
interface inv_sub_bytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    // Round controller side: offers blocks, consumes results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Engine side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes of the 128-bit
// state per clock, byte 0 at [127:120]. Capture in IDLE, substitute in BUSY,
// hold the result in DONE until the downstream stage takes it.
module inv_sub_bytes_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    inv_sub_bytes_iter_if.slave        bus,
    output logic                       busy
);
    localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
    localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

    generate
        if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
            BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_lanes
            $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     state_q, state_d;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = gf_mul(x, x);
        r  = sq;
        for (int i = 0; i < 6; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t;
        t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Next-state logic: capture on accept, substitute one lane group per BUSY cycle.
    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        unique case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = bus.in_data;
                    cnt_d   = '0;
                    fsm_d   = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
                    state_d[127 - 8*(int'(cnt_q)*BYTES_PER_CYCLE + l) -: 8] =
                        inv_sbox(state_q[127 - 8*(int'(cnt_q)*BYTES_PER_CYCLE + l) -: 8]);
                end
                if (cnt_q == LAST_CNT) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State, counter and data registers; reset discards any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign bus.in_ready  = (fsm_q == IDLE);
    assign bus.out_valid = (fsm_q == DONE);
    assign bus.out_data  = state_q;
    assign busy          = (fsm_q == BUSY);
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: three lane widths (4, 1, 16) checked against a
// table model built from the forward S-box definition and inverted.
module tb_inv_sub_bytes_iter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    inv_sub_bytes_iter_if if4 ();
    inv_sub_bytes_iter_if if1 ();
    inv_sub_bytes_iter_if if16 ();
    logic busy4, busy1, busy16;

    logic         iv   [3];
    logic [127:0] idat [3];
    logic         ordy [3];

    assign if4.in_valid   = iv[0];
    assign if4.in_data    = idat[0];
    assign if4.out_ready  = ordy[0];
    assign if1.in_valid   = iv[1];
    assign if1.in_data    = idat[1];
    assign if1.out_ready  = ordy[1];
    assign if16.in_valid  = iv[2];
    assign if16.in_data   = idat[2];
    assign if16.out_ready = ordy[2];

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave),  .busy(busy4));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave),  .busy(busy1));
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave), .busy(busy16));

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]   sbox_t  [256];
    logic [7:0]   isbox_t [256];
    logic [127:0] exp_q [$];

    localparam logic [130:0] RESET_OBS = {1'b1, 1'b0, 1'b0, 128'h0};

    task automatic chk(input string tag, input logic [130:0] got, input logic [130:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {in_ready, out_valid, busy, out_data} of the selected instance
    function automatic logic [130:0] obs(input int s);
        case (s)
            0:       return {if4.in_ready,  if4.out_valid,  busy4,  if4.out_data};
            1:       return {if1.in_ready,  if1.out_valid,  busy1,  if1.out_data};
            default: return {if16.in_ready, if16.out_valid, busy16, if16.out_data};
        endcase
    endfunction

    function automatic int nsteps(input int s);
        return (s == 0) ? 4 : (s == 1) ? 16 : 1;
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if (x > 255) x = x ^ 'h11B;
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from its definition, then invert it as a lookup table.
    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox_t[x]  = s;
            isbox_t[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_block(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = isbox_t[d[127 - 8*k -: 8]];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One block through instance s; holds out_ready low for `hold` cycles
    // after out_valid, pulsing in_valid randomly meanwhile.
    task automatic xfer(input int s, input logic [127:0] d, input int hold,
                        output logic [127:0] got, output int lat);
        logic [130:0] o;
        int g;
        ordy[s] = (hold == 0);
        g = 0;
        o = obs(s);
        while (!o[130] && g < 200) begin step(); o = obs(s); g++; end
        iv[s]   = 1'b1;
        idat[s] = d;
        step();
        iv[s]   = 1'b0;
        idat[s] = {$urandom, $urandom, $urandom, $urandom};
        lat = 1;
        o = obs(s);
        while (!o[129] && lat < 200) begin step(); lat++; o = obs(s); end
        got = o[127:0];
        for (int i = 0; i < hold; i++) begin
            iv[s]   = 1'($urandom_range(0, 1));
            idat[s] = {$urandom, $urandom, $urandom, $urandom};
            step();
            o = obs(s);
            chk("hold_stable", o, {1'b0, 1'b1, 1'b0, got});
        end
        iv[s]   = 1'b0;
        ordy[s] = 1'b1;
        step();
        o = obs(s);
        chk("release_idle", {129'h0, o[130:129]}, {129'h0, 2'b10});
    endtask

    initial begin
        logic [127:0] got, d, x, pat;
        logic [130:0] o;
        int lat, s, last_acc, n_acc, n_done;

        for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; idat[i] = '0; ordy[i] = 1'b1; end
        rst_n = 1'b0;
        build_tables();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) chk("reset_state", obs(i), RESET_OBS);

        xfer(0, 128'h000102030405060708090A0B0C0D0E0F, 0, got, lat);
        chk("single_data", {3'b0, got}, {3'b0, 128'h52096AD53036A538BF40A39E81F3D7FB});
        chk("single_lat", 131'(lat), 131'(5));

        for (int i = 0; i < 3; i++) begin
            xfer(i, {16{8'h63}}, 0, got, lat);
            chk("all63_data", {3'b0, got}, 131'h0);
            chk("all63_lat", 131'(lat), 131'(nsteps(i) + 1));
        end

        // backpressure: ten cycles of out_ready low with spurious in_valid
        d = {$urandom, $urandom, $urandom, $urandom};
        xfer(0, d, 10, got, lat);
        chk("bp_data", {3'b0, got}, {3'b0, ref_block(d)});

        // every byte value, then the forward S-box composed with the engine
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 16; k++) begin
                d[127 - 8*k -: 8] = 8'(16*b + k);
                x[127 - 8*k -: 8] = sbox_t[16*b + k];
            end
            xfer(0, d, $urandom_range(0, 2), got, lat);
            chk("exhaustive", {3'b0, got}, {3'b0, ref_block(d)});
            xfer(0, x, 0, got, lat);
            chk("compose", {3'b0, got}, {3'b0, d});
        end

        for (int i = 0; i < 24; i++) begin
            s = $urandom_range(0, 2);
            d = {$urandom, $urandom, $urandom, $urandom};
            xfer(s, d, $urandom_range(0, 3), got, lat);
            chk("rand_data", {3'b0, got}, {3'b0, ref_block(d)});
            chk("rand_lat", 131'(lat), 131'(nsteps(s) + 1));
        end

        // back-to-back with in_valid held high and alternating patterns
        pat      = {$urandom, $urandom, $urandom, $urandom};
        ordy[0]  = 1'b1;
        iv[0]    = 1'b1;
        idat[0]  = pat;
        last_acc = -1;
        n_acc    = 0;
        n_done   = 0;
        for (int c = 0; c < 80; c++) begin
            o = obs(0);
            if (o[129]) begin
                if (exp_q.size() > 0) begin x = exp_q.pop_front(); chk("b2b_data", {3'b0, o[127:0]}, {3'b0, x}); end
                else chk("b2b_extra", 131'(1), 131'(0));
                n_done++;
            end
            if (o[130]) begin
                if (last_acc >= 0) chk("b2b_gap", 131'(c - last_acc), 131'(nsteps(0) + 2));
                last_acc = c;
                exp_q.push_back(ref_block(idat[0]));
                n_acc++;
            end
            step();
            if (o[130]) idat[0] = n_acc[0] ? ~pat : pat;
        end
        iv[0] = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            o = obs(0);
            if (o[129]) begin x = exp_q.pop_front(); chk("b2b_data", {3'b0, o[127:0]}, {3'b0, x}); n_done++; end
            step();
        end
        chk("b2b_acc", 131'(n_acc), 131'(14));
        chk("b2b_count", 131'(n_done), 131'(n_acc));

        // asynchronous reset in the middle of BUSY
        o = obs(0);
        while (!o[130]) begin step(); o = obs(0); end
        iv[0] = 1'b1;
        idat[0] = {$urandom, $urandom, $urandom, $urandom};
        step();
        iv[0] = 1'b0;
        step();
        o = obs(0);
        chk("pre_rst_busy", {128'h0, o[130:128]}, {128'h0, 3'b001});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", obs(0), RESET_OBS);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst", obs(0), RESET_OBS);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
